// File: rtl/mux_arbiter.sv
// Purpose : two-requester packet mux (0 = forwarded, 1 = local PTP) with packet-atomic grants.
// Latency : one cycle from a data-FIFO pop to out_data; a grant costs one IDLE cycle per packet.
// Backpr. : out_data_alf blocks new grants only; an empty data FIFO mid-packet stalls the output.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   in{0,1}_data_q / _empty / _rd      FWFT data FIFO head word, empty flag, pop strobe
//   in{0,1}_valid_q / _empty / _rd     per-packet keep flag FIFO, empty flag, pop strobe
//   out_data_wr / out_data             registered output word and its write strobe
//   out_data_valid_wr / out_data_valid keep flag written alongside the tail word
//   out_data_alf                       downstream almost-full
//   pkt_cnt0 / pkt_cnt1                packets granted per requester (wrapping)
//
// Build option: define MUX_ARBITER_PTP_PRIO_EN to give requester 1 every tie
// (strict priority); otherwise ties alternate round-robin.

module mux_arbiter (
    input  logic         clk,
    input  logic         rst_n,

    input  logic [133:0] in0_data_q,
    input  logic         in0_data_empty,
    output logic         in0_data_rd,
    input  logic         in0_valid_q,
    input  logic         in0_valid_empty,
    output logic         in0_valid_rd,

    input  logic [133:0] in1_data_q,
    input  logic         in1_data_empty,
    output logic         in1_data_rd,
    input  logic         in1_valid_q,
    input  logic         in1_valid_empty,
    output logic         in1_valid_rd,

    output logic         out_data_wr,
    output logic [133:0] out_data,
    output logic         out_data_valid_wr,
    output logic         out_data_valid,

    input  logic         out_data_alf,
    output logic [31:0]  pkt_cnt0,
    output logic [31:0]  pkt_cnt1
);

    localparam logic [1:0] TAG_TAIL = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        TRANS = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           grant_q, grant_d;   // requester owning the current packet
    logic           last_q,  last_d;    // requester granted most recently
    logic [31:0]    cnt0_q,  cnt0_d;
    logic [31:0]    cnt1_q,  cnt1_d;
    logic           wr_q,    wr_d;
    logic [133:0]   dat_q,   dat_d;
    logic           vwr_q,   vwr_d;
    logic           vld_q,   vld_d;

    logic           elig0, elig1;
    logic           tie_pick;
    logic           pick;
    logic           pop;
    logic           tail;
    logic           sel_empty;
    logic [133:0]   sel_word;
    logic           sel_valid;

    // A packet is eligible only once its keep flag is queued, i.e. the whole
    // packet is already in the data FIFO.
    assign elig0 = ~in0_valid_empty;
    assign elig1 = ~in1_valid_empty;

`ifdef MUX_ARBITER_PTP_PRIO_EN
    assign tie_pick = 1'b1;
`else
    assign tie_pick = ~last_q;
`endif

    assign sel_empty = grant_q ? in1_data_empty : in0_data_empty;
    assign sel_word  = grant_q ? in1_data_q     : in0_data_q;
    assign sel_valid = grant_q ? in1_valid_q    : in0_valid_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        wr_d    = 1'b0;
        dat_d   = '0;
        vwr_d   = 1'b0;
        vld_d   = 1'b0;
        pick    = 1'b0;
        pop     = 1'b0;
        tail    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!out_data_alf && (elig0 || elig1)) begin
                    pick    = (elig0 && elig1) ? tie_pick : elig1;
                    grant_d = pick;
                    last_d  = pick;
                    if (pick) cnt1_d = cnt1_q + 32'd1;
                    else      cnt0_d = cnt0_q + 32'd1;
                    state_d = TRANS;
                end
            end
            TRANS: begin
                // Words are forwarded verbatim; a stray head tag mid-packet is
                // not treated as a framing error.
                if (!sel_empty) begin
                    pop   = 1'b1;
                    wr_d  = 1'b1;
                    dat_d = sel_word;
                    if (sel_word[133:132] == TAG_TAIL) begin
                        tail    = 1'b1;
                        vwr_d   = 1'b1;
                        vld_d   = sel_valid;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pops are combinational from the current state; held off during reset so
    // upstream FIFOs are left untouched while the packet is abandoned.
    assign in0_data_rd  = rst_n & pop  & ~grant_q;
    assign in1_data_rd  = rst_n & pop  &  grant_q;
    assign in0_valid_rd = rst_n & tail & ~grant_q;
    assign in1_valid_rd = rst_n & tail &  grant_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;    // requester 0 wins the first tie
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            wr_q    <= 1'b0;
            dat_q   <= '0;
            vwr_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            wr_q    <= wr_d;
            dat_q   <= dat_d;
            vwr_q   <= vwr_d;
            vld_q   <= vld_d;
        end
    end

    assign out_data_wr       = wr_q;
    assign out_data          = dat_q;
    assign out_data_valid_wr = vwr_q;
    assign out_data_valid    = vld_q;
    assign pkt_cnt0          = cnt0_q;
    assign pkt_cnt1          = cnt1_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Purpose : directed self-checking bench for mux_arbiter.
// Latency : expected output cycles are computed from packet start cycles.
// Backpr. : almost-full and data-FIFO stalls are driven from per-cycle controls.

module tb_mux_arbiter;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic [133:0] in0_data_q = '0;
    logic         in0_data_empty = 1'b1;
    logic         in0_data_rd;
    logic         in0_valid_q = 1'b0;
    logic         in0_valid_empty = 1'b1;
    logic         in0_valid_rd;
    logic [133:0] in1_data_q = '0;
    logic         in1_data_empty = 1'b1;
    logic         in1_data_rd;
    logic         in1_valid_q = 1'b0;
    logic         in1_valid_empty = 1'b1;
    logic         in1_valid_rd;
    logic         out_data_wr;
    logic [133:0] out_data;
    logic         out_data_valid_wr;
    logic         out_data_valid;
    logic         out_data_alf = 1'b0;
    logic [31:0]  pkt_cnt0;
    logic [31:0]  pkt_cnt1;

    mux_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in0_data_q        (in0_data_q),
        .in0_data_empty    (in0_data_empty),
        .in0_data_rd       (in0_data_rd),
        .in0_valid_q       (in0_valid_q),
        .in0_valid_empty   (in0_valid_empty),
        .in0_valid_rd      (in0_valid_rd),
        .in1_data_q        (in1_data_q),
        .in1_data_empty    (in1_data_empty),
        .in1_data_rd       (in1_data_rd),
        .in1_valid_q       (in1_valid_q),
        .in1_valid_empty   (in1_valid_empty),
        .in1_valid_rd      (in1_valid_rd),
        .out_data_wr       (out_data_wr),
        .out_data          (out_data),
        .out_data_valid_wr (out_data_valid_wr),
        .out_data_valid    (out_data_valid),
        .out_data_alf      (out_data_alf),
        .pkt_cnt0          (pkt_cnt0),
        .pkt_cnt1          (pkt_cnt1)
    );

    typedef struct {
        int           c;
        logic [133:0] d;
        logic         vw;
        logic         v;
    } ent_t;

    logic [133:0] q0[$];
    logic [133:0] q1[$];
    logic         v0[$];
    logic         v1[$];
    ent_t         log_q[$];
    ent_t         exp_q[$];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   idle_bad = 0;
    int   c0 = 0;
    logic rst_r = 1'b0;
    logic alf_r = 1'b0;
    logic stall0 = 1'b0;

    task automatic check_val(input string tag, input logic [133:0] got, input logic [133:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [133:0] make_word(input int req, input int pkt, input int idx, input int n);
        logic [1:0] t;
        t = (idx == 0) ? 2'b01 : ((idx == n - 1) ? 2'b10 : 2'b11);
        return {t, 108'd0, 8'(req), 8'(pkt), 8'(idx)};
    endfunction

    task automatic push_pkt(input int req, input int pkt, input int n, input logic vf);
        for (int j = 0; j < n; j++) begin
            if (req == 0) q0.push_back(make_word(req, pkt, j, n));
            else          q1.push_back(make_word(req, pkt, j, n));
        end
        if (req == 0) v0.push_back(vf);
        else          v1.push_back(vf);
    endtask

    task automatic expect_word(input int c, input logic [133:0] d, input logic vw, input logic v);
        ent_t e;
        e.c = c; e.d = d; e.vw = vw; e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic exp_pkt(input int req, input int pkt, input int n, input logic vf, input int start);
        for (int j = 0; j < n; j++)
            expect_word(start + j, make_word(req, pkt, j, n), (j == n - 1), (j == n - 1) && vf);
    endtask

    task automatic drive();
        rst_n           = rst_r;
        out_data_alf    = alf_r;
        in0_data_q      = (q0.size() > 0) ? q0[0] : '0;
        in0_data_empty  = (q0.size() == 0) || stall0;
        in0_valid_q     = (v0.size() > 0) ? v0[0] : 1'b0;
        in0_valid_empty = (v0.size() == 0);
        in1_data_q      = (q1.size() > 0) ? q1[0] : '0;
        in1_data_empty  = (q1.size() == 0);
        in1_valid_q     = (v1.size() > 0) ? v1[0] : 1'b0;
        in1_valid_empty = (v1.size() == 0);
    endtask

    // One clock: sample at the falling edge, then apply pops and new inputs
    // just after the rising edge.
    task automatic step();
        logic p0d, p0v, p1d, p1v;
        ent_t e;
        @(negedge clk);
        p0d = in0_data_rd; p0v = in0_valid_rd;
        p1d = in1_data_rd; p1v = in1_valid_rd;
        if (out_data_wr === 1'b1) begin
            e.c = cyc; e.d = out_data; e.vw = out_data_valid_wr; e.v = out_data_valid;
            log_q.push_back(e);
        end else if (out_data_wr === 1'b0 &&
                     (out_data !== '0 || out_data_valid_wr !== 1'b0 || out_data_valid !== 1'b0)) begin
            idle_bad++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (p0d && q0.size() > 0) q0.delete(0);
        if (p0v && v0.size() > 0) v0.delete(0);
        if (p1d && q1.size() > 0) q1.delete(0);
        if (p1v && v1.size() > 0) v1.delete(0);
        drive();
    endtask

    task automatic compare_log(input string tag);
        check_val({tag, "_len"}, 134'(log_q.size()), 134'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
            check_val($sformatf("%s_cyc%0d", tag, k), 134'(log_q[k].c), 134'(exp_q[k].c));
            check_val($sformatf("%s_dat%0d", tag, k), log_q[k].d, exp_q[k].d);
            check_val($sformatf("%s_vwr%0d", tag, k), 134'(log_q[k].vw), 134'(exp_q[k].vw));
            check_val($sformatf("%s_vld%0d", tag, k), 134'(log_q[k].v), 134'(exp_q[k].v));
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_r = 1'b0;
        step();
        step();
        rst_r = 1'b1;
        step();
        log_q.delete();
    endtask

    initial begin
        int owner;
        int pid0;
        int pid1;

        // Reset state
        drive();
        rst_r = 1'b0;
        repeat (3) step();
        check_val("rst_wr",   134'(out_data_wr), 134'(0));
        check_val("rst_dat",  out_data, '0);
        check_val("rst_vwr",  134'(out_data_valid_wr), 134'(0));
        check_val("rst_vld",  134'(out_data_valid), 134'(0));
        check_val("rst_cnt0", 134'(pkt_cnt0), 134'(0));
        check_val("rst_cnt1", 134'(pkt_cnt1), 134'(0));
        rst_r = 1'b1;
        step();
        log_q.delete();

        // Single 4-word packet on requester 0
        push_pkt(0, 1, 4, 1'b1);
        drive();
        c0 = cyc;
        exp_pkt(0, 1, 4, 1'b1, c0 + 2);
        for (int i = 1; i <= 8; i++) step();
        compare_log("single");
        check_val("single_cnt0", 134'(pkt_cnt0), 134'(1));
        check_val("single_cnt1", 134'(pkt_cnt1), 134'(0));

        // Three 3-word packets on each requester from reset
        do_reset();
        check_val("rr_rst_cnt0", 134'(pkt_cnt0), 134'(0));
        for (int k = 0; k < 3; k++) begin
            push_pkt(0, 20 + k, 3, 1'b1);
            push_pkt(1, 30 + k, 3, 1'b1);
        end
        drive();
        c0 = cyc;
        pid0 = 20;
        pid1 = 30;
        for (int k = 0; k < 6; k++) begin
`ifdef MUX_ARBITER_PTP_PRIO_EN
            owner = (k < 3) ? 1 : 0;
`else
            owner = k % 2;
`endif
            if (owner == 0) begin exp_pkt(0, pid0, 3, 1'b1, c0 + 2 + k * 4); pid0++; end
            else            begin exp_pkt(1, pid1, 3, 1'b1, c0 + 2 + k * 4); pid1++; end
        end
        for (int i = 1; i <= 30; i++) step();
        compare_log("order");
        check_val("order_cnt0", 134'(pkt_cnt0), 134'(3));
        check_val("order_cnt1", 134'(pkt_cnt1), 134'(3));

        // Almost-full raised during word 2 of a 6-word packet
        push_pkt(0, 40, 6, 1'b1);
        drive();
        c0 = cyc;
        exp_pkt(0, 40, 6, 1'b1, c0 + 2);
        exp_pkt(1, 41, 2, 1'b1, c0 + 15);
        for (int i = 1; i <= 20; i++) begin
            if (i == 2) push_pkt(1, 41, 2, 1'b1);
            alf_r = (i >= 2 && i <= 12);
            step();
        end
        alf_r = 1'b0;
        compare_log("alf");
        check_val("alf_cnt0", 134'(pkt_cnt0), 134'(4));
        check_val("alf_cnt1", 134'(pkt_cnt1), 134'(4));

        // Data FIFO runs dry for 3 cycles mid-packet; keep flag 0
        push_pkt(0, 50, 5, 1'b0);
        drive();
        c0 = cyc;
        expect_word(c0 + 2, make_word(0, 50, 0, 5), 1'b0, 1'b0);
        expect_word(c0 + 3, make_word(0, 50, 1, 5), 1'b0, 1'b0);
        expect_word(c0 + 7, make_word(0, 50, 2, 5), 1'b0, 1'b0);
        expect_word(c0 + 8, make_word(0, 50, 3, 5), 1'b0, 1'b0);
        expect_word(c0 + 9, make_word(0, 50, 4, 5), 1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            stall0 = (i >= 3 && i <= 5);
            step();
        end
        stall0 = 1'b0;
        compare_log("stall");

        // One-cycle reset during word 3 of an 8-word packet; upstream also flushed
        push_pkt(0, 60, 8, 1'b1);
        drive();
        c0 = cyc;
        exp_pkt(0, 60, 2, 1'b1, c0 + 2);
        exp_q[1].vw = 1'b0;
        exp_q[1].v  = 1'b0;
        exp_q[1].d  = make_word(0, 60, 1, 8);
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) begin
                rst_r = 1'b0;
                q0.delete();
                v0.delete();
            end
            if (i == 4) rst_r = 1'b1;
            step();
            if (i == 4) begin
                check_val("mrst_wr",   134'(out_data_wr), 134'(0));
                check_val("mrst_dat",  out_data, '0);
                check_val("mrst_vwr",  134'(out_data_valid_wr), 134'(0));
                check_val("mrst_cnt0", 134'(pkt_cnt0), 134'(0));
                check_val("mrst_cnt1", 134'(pkt_cnt1), 134'(0));
            end
        end
        compare_log("mrst");

        // Grant pointer restored by reset: first tie after reset
        push_pkt(0, 70, 2, 1'b1);
        push_pkt(1, 71, 2, 1'b0);
        drive();
        c0 = cyc;
`ifdef MUX_ARBITER_PTP_PRIO_EN
        exp_pkt(1, 71, 2, 1'b0, c0 + 2);
        exp_pkt(0, 70, 2, 1'b1, c0 + 5);
`else
        exp_pkt(0, 70, 2, 1'b1, c0 + 2);
        exp_pkt(1, 71, 2, 1'b0, c0 + 5);
`endif
        for (int i = 1; i <= 10; i++) step();
        compare_log("tie");
        check_val("tie_cnt0", 134'(pkt_cnt0), 134'(1));
        check_val("tie_cnt1", 134'(pkt_cnt1), 134'(1));

        check_val("idle_zero", 134'(idle_bad), 134'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst_n  in  1  reset, synchronous, active-low, sampled on rising clk.
REQ-002 SHALL have, per requester i in {0,1} (0 = forwarded traffic, 1 = local PTP): in{i}_data_q  in  134  FWFT data FIFO head word; in{i}_data_empty  in  1; in{i}_data_rd  out  1  pop data FIFO.
REQ-003 SHALL have, per requester i: in{i}_valid_q  in  1  per-packet keep flag; in{i}_valid_empty  in  1  no complete packet queued; in{i}_valid_rd  out  1  pop valid FIFO.
REQ-004 SHALL have outputs: out_data_wr  out  1; out_data  out  134; out_data_valid_wr  out  1; out_data_valid  out  1.
REQ-005 SHALL have: out_data_alf  in  1  downstream almost-full; pkt_cnt0, pkt_cnt1  out  32  packets granted per requester.
REQ-006 SHALL use word tag bits [133:132]: 01 head, 11 middle, 10 tail.

Function
REQ-007 SHALL implement states IDLE and TRANS.
REQ-008 Requester i SHALL be eligible when in{i}_valid_empty=0; arbitration SHALL occur only in IDLE and only when out_data_alf=0.
REQ-009 Arbitration SHALL be round-robin: with both eligible, grant the requester not granted last; last-grant pointer resets to 1 (so requester 0 wins first tie).
REQ-010 On grant in IDLE cycle t, SHALL register grant, increment pkt_cnt{grant} (32-bit wrap), enter TRANS at t+1.
REQ-011 In TRANS, in{g}_data_rd SHALL be asserted combinationally when in{g}_data_empty=0; the other requester's rd strobes SHALL be 0.
REQ-012 Each word popped at cycle k SHALL appear on out_data with out_data_wr=1 at cycle k+1 (one-cycle latency, registered).
REQ-013 If in{g}_data_empty=1 mid-packet, SHALL pause: no pop, out_data_wr=0 next cycle, remain in TRANS.
REQ-014 When the popped word's tag is 10, SHALL assert in{g}_valid_rd the same cycle, and at k+1 assert out_data_valid_wr=1 with out_data_valid=in{g}_valid_q sampled at k, coincident with the tail out_data_wr.
REQ-015 After tail pop, SHALL return to IDLE at k+1; minimum one idle cycle between packets.
REQ-016 out_data_alf SHALL NOT interrupt a packet in TRANS; it only blocks new grants.
REQ-017 Words popped in IDLE SHALL be none; a head word (tag 01) seen mid-packet SHALL be forwarded unchanged (no framing repair).
REQ-018 When not writing, out_data_wr, out_data_valid_wr, out_data_valid SHALL be 0 and out_data SHALL be 0.

Reset
REQ-019 With rst_n=0 at a rising edge: state IDLE, all outputs 0, pkt_cnt0/1 = 0, grant pointer = 1; rd strobes 0 while rst_n=0.
REQ-020 Reset mid-packet SHALL abandon the packet; no further words of it are emitted; upstream FIFOs are not drained by this block.

Configuration
REQ-021 Macro MUX_ARBITER_PTP_PRIO_EN: when defined, requester 1 SHALL win every tie (strict priority), round-robin pointer unused; when undefined, REQ-009 round-robin applies.

Verification
REQ-022 Single 4-word packet (01,11,11,10) on in0, valid_q=1, alf=0 -> 4 out_data_wr cycles starting 2 cycles after valid_empty falls; valid_wr=1,valid=1 with tail; pkt_cnt0=1.
REQ-023 Both requesters hold 3 packets each from reset, macro undefined -> output order 0,1,0,1,0,1, each packet contiguous, one idle cycle between.
REQ-024 Same stimulus with MUX_ARBITER_PTP_PRIO_EN defined -> order 1,1,1,0,0,0.
REQ-025 out_data_alf=1 raised during word 2 of a 6-word packet -> packet completes all 6 words; no new grant until alf=0.
REQ-026 in0_data_empty=1 for 3 cycles mid-packet -> 3-cycle gap in out_data_wr, words intact, tail valid_q=0 gives out_data_valid=0 with valid_wr=1.
REQ-027 rst_n=0 for one cycle during word 3 of an 8-word packet -> all outputs 0 next cycle, counters 0, state IDLE.
